// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate-extension logic.
// Used by the extender pipeline and by the ALU-immediate path.
package imm_ext_pkg;

   localparam int IMM_W  = 16;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      MODE_SEXT  = 2'b00,
      MODE_ZEXT  = 2'b01,
      MODE_UPPER = 2'b10,
      MODE_SHL2  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Producer/consumer handshake bundle for the immediate extender.
// The slave modport is the extender's view; the master modport is the environment's view.
interface imm_extend_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;

   modport slave (
      input  flush, in_valid, in_imm, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output flush, in_valid, in_imm, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper-placed and branch-offset forms.
// Shared with the ALU-immediate path, so it carries no state.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic [IN_W-1:0]  imm,
   input  mode_e            mode,
   output logic [OUT_W-1:0] result
);

   logic [OUT_W-1:0] sext;

   always_comb begin
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      unique case (mode)
         MODE_SEXT:  result = sext;
         MODE_ZEXT:  result = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_UPPER: result = {imm, {(OUT_W-IN_W){1'b0}}};
         MODE_SHL2:  result = {sext[OUT_W-3:0], 2'b00};
         default:    result = sext;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a 2-entry skid buffer (M drives the output, S absorbs
// one extra result under backpressure) and a synchronous flush for pipeline redirects.
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   imm_extend_pipe_if.slave bus
);

   if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
      $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W + 2");
   end

   logic [OUT_W-1:0] result;
   state_e           state_q, state_d;
   logic [OUT_W-1:0] m_q, m_d;
   logic [OUT_W-1:0] s_q, s_d;
   logic             in_ready_q, in_ready_d;
   logic             in_xfer, out_xfer;

   imm_ext_core #(
      .IN_W (IN_W),
      .OUT_W(OUT_W)
   ) u_core (
      .imm   (bus.in_imm),
      .mode  (mode_e'(bus.in_mode)),
      .result(result)
   );

   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_data  = m_q;
   assign bus.in_ready  = in_ready_q;

   assign in_xfer  = bus.in_valid && in_ready_q;
   assign out_xfer = bus.out_valid && bus.out_ready;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: if (in_xfer) begin
               state_d = ST_ONE;
               m_d     = result;
            end
            ST_ONE: begin
               if (in_xfer && !out_xfer) begin
                  state_d = ST_TWO;
                  s_d     = result;
               end else if (in_xfer && out_xfer) begin
                  m_d = result;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: if (out_xfer) begin
               state_d = ST_ONE;
               m_d     = s_q;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Ready is a flop of the next state, so it never sees out_ready combinationally.
      in_ready_d = (state_d != ST_TWO);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: M and S are data registers, but reset clears them so out_data is a known 0.
         state_q    <= ST_EMPTY;
         m_q        <= '0;
         s_q        <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         s_q        <= s_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: queue-based reference of the extender pipeline plus directed scenarios.
module tb_imm_extend_pipe;
   import imm_ext_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

   imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Narrow instance of the shared core for the parameter sweep.
   logic [11:0] sw_imm;
   mode_e       sw_mode;
   logic [15:0] sw_res;
   imm_ext_core #(.IN_W(12), .OUT_W(16)) u_sweep (
      .imm   (sw_imm),
      .mode  (sw_mode),
      .result(sw_res)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference extension from the arithmetic meaning of each mode.
   function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
      longint v;
      longint r;
      v = longint'(imm);
      if (imm >= 16'h8000) v = v - 65536;
      case (mode)
         2'b00:   r = v;
         2'b01:   r = longint'(imm);
         2'b10:   r = longint'(imm) * 65536;
         default: r = v * 4;
      endcase
      return r[31:0];
   endfunction

   // Reference pipeline: a FIFO of at most two results.
   logic [31:0] q[$];
   logic [31:0] obs[$];
   bit          m_rdy, m_vld;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         m_rdy = (q.size() < 2);
         m_vld = (q.size() > 0);
         if (m_vld && bus.out_ready) void'(q.pop_front());
         if (bus.flush) q.delete();
         else if (bus.in_valid && m_rdy) q.push_back(model_ext(bus.in_imm, bus.in_mode));
      end
   end

   always @(negedge clk) begin
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) check("out_data", bus.out_data, q[0]);
      if (bus.out_valid && bus.out_ready) obs.push_back(bus.out_data);
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic offer(input logic [15:0] imm, input logic [1:0] mode, output int waits);
      bit rdy;
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_imm   = imm;
      bus.in_mode  = mode;
      forever begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         waits++;
         if (waits > 50) begin
            check("offer_timeout", 32'(waits), 32'd0);
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_one(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp,
                           input string name);
      int w;
      offer(imm, mode, w);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check(name, bus.out_data, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_imm    = '0;
      bus.in_mode   = '0;
      bus.out_ready = 1'b1;

      // Pin the reference model to hand-computed values.
      check("model_sext", model_ext(16'h8000, MODE_SEXT), 32'hFFFF8000);
      check("model_zext", model_ext(16'h8000, MODE_ZEXT), 32'h00008000);
      check("model_upper", model_ext(16'h1234, MODE_UPPER), 32'h12340000);
      check("model_shl2", model_ext(16'hFFFF, MODE_SHL2), 32'hFFFFFFFC);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_out_data", bus.out_data, 32'd0);
      @(posedge clk);
      #1;

      // Modes, 1-cycle latency.
      send_one(16'h8000, MODE_SEXT, 32'hFFFF8000, "mode_sext");
      send_one(16'h8000, MODE_ZEXT, 32'h00008000, "mode_zext");
      send_one(16'h1234, MODE_UPPER, 32'h12340000, "mode_upper");
      send_one(16'hFFFF, MODE_SHL2, 32'hFFFFFFFC, "mode_shl2_neg");
      send_one(16'h0004, MODE_SHL2, 32'h00000010, "mode_shl2_pos");
      idle(2);

      // Streaming at full rate.
      obs.delete();
      for (int i = 1; i <= 8; i++) begin
         offer(16'(i), MODE_SEXT, w);
         check("stream_no_stall", 32'(w), 32'd0);
      end
      idle(3);
      check("stream_count", 32'(obs.size()), 32'd8);
      for (int i = 0; i < 8 && i < obs.size(); i++)
         check("stream_value", obs[i], 32'(i + 1));

      // Backpressure: two accepted, third held.
      bus.out_ready = 1'b0;
      offer(16'h0011, MODE_SEXT, w);
      check("bp_first_wait", 32'(w), 32'd0);
      offer(16'h0022, MODE_SEXT, w);
      check("bp_second_wait", 32'(w), 32'd0);
      bus.in_imm = 16'h0033;
      repeat (2) begin
         @(negedge clk);
         check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
         check("bp_data_stable", bus.out_data, 32'h00000011);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      obs.delete();
      offer(16'h0033, MODE_SEXT, w);
      idle(4);
      check("bp_count", 32'(obs.size()), 32'd3);
      if (obs.size() == 3) begin
         check("bp_order0", obs[0], 32'h11);
         check("bp_order1", obs[1], 32'h22);
         check("bp_order2", obs[2], 32'h33);
      end
      check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);

      // Flush from TWO with a concurrent input.
      bus.out_ready = 1'b0;
      offer(16'h0055, MODE_SEXT, w);
      offer(16'h0066, MODE_SEXT, w);
      bus.in_valid = 1'b1;
      bus.in_imm   = 16'h0044;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.out_ready = 1'b1;
      obs.delete();
      idle(3);
      check("flush_nothing_out", 32'(obs.size()), 32'd0);

      // Reset mid-operation from TWO.
      bus.out_ready = 1'b0;
      offer(16'h0077, MODE_SEXT, w);
      offer(16'h0088, MODE_SEXT, w);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_async_data", bus.out_data, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_rel_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_one(16'h7FFF, MODE_SEXT, 32'h00007FFF, "rst_first_result");

      // Narrow-parameter sweep of the shared core.
      sw_imm  = 12'h800;
      sw_mode = MODE_SEXT;
      #1;
      check("sweep_sext", {16'd0, sw_res}, 32'h0000F800);
      sw_imm  = 12'hABC;
      sw_mode = MODE_UPPER;
      #1;
      check("sweep_upper", {16'd0, sw_res}, 32'h0000ABC0);

      // Randomized traffic against the reference queue.
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_imm    = 16'($urandom);
         bus.in_mode   = 2'($urandom_range(0, 3));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         @(posedge clk);
         #1;
      end
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate extender for the decode stage. Takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand: sign-extended, zero-extended, upper-placed (LUI), or sign-extended and shifted left by 2 (branch offset). The output is registered behind a valid/ready handshake. A 2-entry skid buffer keeps full throughput under backpressure, and a synchronous flush drops in-flight entries on a pipeline redirect.

## Interface
- IN_W, default 16, immediate width; must be ≥ 2.
- OUT_W, default 32, output width; must be ≥ IN_W + 2 (elaboration-time assertion).
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- flush, input, 1, synchronous drop of all buffered entries.
- in_valid, input, 1, producer presents an immediate.
- in_ready, output, 1, block can accept; registered.
- in_imm, input, IN_W, immediate.
- in_mode, input, 2, extension mode (see Operation).
- out_valid, output, 1, out_data holds a result.
- out_ready, input, 1, consumer accepts.
- out_data, output, OUT_W, extended operand.

## Operation
- Modes:
  - 00 SEXT: {replicate in_imm[IN_W-1], in_imm}.
  - 01 ZEXT: {zeros, in_imm}.
  - 10 UPPER: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], low bits zero.
  - 11 SEXT_SHL2: SEXT result shifted left 2, with the top 2 bits discarded.
- Extension is computed combinationally on input acceptance; only the result is stored, not the mode.
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.
- Storage: main register M (drives out_data) and skid register S.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: M valid, in_ready=1.
  - TWO: M and S valid, in_ready=0.
- Transitions (no flush):
  - EMPTY + in xfer → ONE (M ← result).
  - ONE + in xfer, no out xfer → TWO (S ← result).
  - ONE + in xfer + out xfer → ONE (M ← result).
  - ONE + out xfer only → EMPTY.
  - TWO + out xfer → ONE (M ← S).
  - TWO without out xfer → stays TWO; no input can arrive because in_ready=0.
- Ordering is strict FIFO; no result is dropped or duplicated except on flush.
- flush = 1: next state EMPTY, regardless of in_valid and out_ready.
  - An input presented in the flush cycle is discarded.
  - An out transfer in the flush cycle still completes (the consumer sampled it).
- out_data holds its last value when out_valid=0; consumers must not rely on it.
- While out_valid=1 and out_ready=0, out_data is stable.

## Timing
- Reset values: state EMPTY, out_valid=0, out_data=0, in_ready=1, S=0. Reset takes effect immediately (asynchronous) and is released synchronously to clk.
- Reset mid-operation: all entries are lost. The first cycle after rst_n rises shows in_ready=1, out_valid=0.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 result per cycle while out_ready=1.
- Backpressure: with out_ready held low, exactly 2 inputs are accepted, then in_ready falls in the cycle after the second acceptance.
- in_ready depends only on state, never combinationally on out_ready.

## Structure
- Shared package imm_ext_pkg:
  - mode typedef: 2-bit enum, MODE_SEXT, MODE_ZEXT, MODE_UPPER, MODE_SHL2.
  - state typedef: ST_EMPTY, ST_ONE, ST_TWO.
  - Default width constants IMM_W=16 and WORD_W=32.
- Sub-module imm_ext_core: purely combinational, parameters IN_W and OUT_W, inputs (imm, mode), output result. Reused by later ALU-immediate logic.
- imm_extend_pipe instantiates one imm_ext_core and holds the state machine, M and S.

## Test plan
- Modes, out_ready=1:
  - 0x8000 SEXT → 0xFFFF8000.
  - 0x8000 ZEXT → 0x00008000.
  - 0x1234 UPPER → 0x12340000.
  - 0xFFFF SHL2 → 0xFFFFFFFC.
  - 0x0004 SHL2 → 0x00000010.
  - Each appears 1 cycle after acceptance.
- Streaming: 8 back-to-back inputs (0x0001..0x0008, SEXT) with out_ready=1 → 8 consecutive out_valid cycles, values 0x00000001..0x00000008, in_ready never drops.
- Backpressure: out_ready=0, offer 0x0011, 0x0022, 0x0033 → first two accepted, in_ready=0, out_data=0x00000011 stable. Raise out_ready → outputs 0x11, 0x22, 0x33 in order, in_ready returns to 1.
- Flush: state TWO, assert flush with in_valid=1 (0x0044) → next cycle out_valid=0, in_ready=1. 0x0044 never appears.
- Reset mid-operation: state TWO, pull rst_n low for 1 cycle → out_valid=0 and out_data=0 immediately; after release, in_ready=1 and the next input (0x7FFF SEXT) yields 0x00007FFF with 1-cycle latency.
- Parameter sweep: IN_W=12, OUT_W=16 → 0x800 SEXT gives 0xF800, 0xABC UPPER gives 0xABC0.
